// File: rtl/rf_writeback_queue_pkg.sv
// Shared constants for the register-file writeback queue slice.
// Widths here are the defaults for the integer register file write side.
package rf_writeback_queue_pkg;

  localparam int XLEN_BUS      = 64;
  localparam int REG_INDEX_BUS = 5;

  localparam logic W_REG_EN = 1'b1;
  localparam logic RESET_EN = 1'b0;

  localparam logic [XLEN_BUS-1:0] ZERO = '0;

endpackage

// File: rtl/rf_wbq_fwd_lookup.sv
// Youngest-match search over the occupied window of the writeback queue.
// Purely combinational; one instance per forwarding query port.
module rf_wbq_fwd_lookup
  import rf_writeback_queue_pkg::*;
#(
  parameter int XLEN      = XLEN_BUS,
  parameter int REG_IDX_W = REG_INDEX_BUS,
  parameter int DEPTH     = 4,
  parameter int PTR_W     = $clog2(DEPTH),
  parameter int CNT_W     = PTR_W + 1
) (
  input  logic [REG_IDX_W-1:0] ent_rd   [DEPTH],
  input  logic [XLEN-1:0]      ent_data [DEPTH],
  input  logic [PTR_W-1:0]     head,
  input  logic [CNT_W-1:0]     count,
  input  logic [REG_IDX_W-1:0] q_id,
  output logic                 hit,
  output logic [XLEN-1:0]      data
);

  logic [PTR_W-1:0] idx;

  // NOTE: every variable driven here gets a default before the loop, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    hit  = 1'b0;
    data = XLEN'(ZERO);
    idx  = head;
    // Walk oldest to youngest; a later match overwrites an earlier one.
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (q_id != '0) && (ent_rd[idx] == q_id)) begin
        hit  = 1'b1;
        data = ent_data[idx];
      end
    end
  end

endmodule

// File: rtl/rf_writeback_queue.sv
// Program-ordered writeback buffer between the dual commit pair and the
// dual-write-port integer register file, with two forwarding query ports.
module rf_writeback_queue
  import rf_writeback_queue_pkg::*;
#(
  parameter int XLEN      = XLEN_BUS,
  parameter int REG_IDX_W = REG_INDEX_BUS,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       wb_hold,
  input  logic                       in0_valid,
  input  logic [REG_IDX_W-1:0]       in0_rd,
  input  logic [XLEN-1:0]            in0_data,
  input  logic                       in1_valid,
  input  logic [REG_IDX_W-1:0]       in1_rd,
  input  logic [XLEN-1:0]            in1_data,
  output logic                       in_ready,
  output logic                       wen0,
  output logic [REG_IDX_W-1:0]       wreg_id0,
  output logic [XLEN-1:0]            wreg_data0,
  output logic                       wen1,
  output logic [REG_IDX_W-1:0]       wreg_id1,
  output logic [XLEN-1:0]            wreg_data1,
  input  logic [REG_IDX_W-1:0]       q0_id,
  input  logic [REG_IDX_W-1:0]       q1_id,
  output logic                       q0_hit,
  output logic                       q1_hit,
  output logic [XLEN-1:0]            q0_data,
  output logic [XLEN-1:0]            q1_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // A commit pair is only taken when two slots are free, regardless of how
  // many of its lanes actually carry a result.
  localparam logic [CNT_W-1:0] MAX_FILL = CNT_W'(DEPTH - 2);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

  logic [REG_IDX_W-1:0] rd_mem   [DEPTH];
  logic [XLEN-1:0]      data_mem [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] cnt;

  logic             ready_int;
  logic             store0;
  logic             store1;
  logic [PTR_W-1:0] slot1;
  logic [PTR_W-1:0] head1;
  logic             drain0;
  logic             drain1;
  logic [1:0]       n_push;
  logic [1:0]       n_pop;

  logic             fwd0_hit;
  logic             fwd1_hit;
  logic [XLEN-1:0]  fwd0_data;
  logic [XLEN-1:0]  fwd1_data;

  always_comb begin
    ready_int = rstn && !flush && (cnt <= MAX_FILL);

    // Results targeting x0 are architecturally discarded, so never buffered.
    store0 = ready_int && in0_valid && (in0_rd != '0);
    store1 = ready_int && in1_valid && (in1_rd != '0);
    slot1  = store0 ? tail + PTR_W'(1) : tail;
    n_push = {1'b0, store0} + {1'b0, store1};

    head1  = head + PTR_W'(1);
    drain0 = rstn && !wb_hold && !flush && (cnt != '0);
    drain1 = rstn && !wb_hold && !flush && (cnt >= TWO);
    n_pop  = {1'b0, drain0} + {1'b0, drain1};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rstn == RESET_EN) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + PTR_W'(n_pop);
      tail <= tail + PTR_W'(n_push);
      cnt  <= cnt + CNT_W'(n_push) - CNT_W'(n_pop);
    end
  end

  // NOTE: the entry storage has no reset; cnt alone defines which slots are
  // live, so stale contents are never written back or forwarded.
  always_ff @(posedge clk) begin
    if (store0) begin
      rd_mem[tail]   <= in0_rd;
      data_mem[tail] <= in0_data;
    end
    if (store1) begin
      rd_mem[slot1]   <= in1_rd;
      data_mem[slot1] <= in1_data;
    end
  end

  rf_wbq_fwd_lookup #(
    .XLEN      (XLEN),
    .REG_IDX_W (REG_IDX_W),
    .DEPTH     (DEPTH),
    .PTR_W     (PTR_W),
    .CNT_W     (CNT_W)
  ) u_fwd0 (
    .ent_rd   (rd_mem),
    .ent_data (data_mem),
    .head     (head),
    .count    (cnt),
    .q_id     (q0_id),
    .hit      (fwd0_hit),
    .data     (fwd0_data)
  );

  rf_wbq_fwd_lookup #(
    .XLEN      (XLEN),
    .REG_IDX_W (REG_IDX_W),
    .DEPTH     (DEPTH),
    .PTR_W     (PTR_W),
    .CNT_W     (CNT_W)
  ) u_fwd1 (
    .ent_rd   (rd_mem),
    .ent_data (data_mem),
    .head     (head),
    .count    (cnt),
    .q_id     (q1_id),
    .hit      (fwd1_hit),
    .data     (fwd1_data)
  );

  // Everything visible outside is held at zero while rstn is low.
  always_comb begin
    in_ready   = ready_int;
    wen0       = drain0 & W_REG_EN;
    wen1       = drain1 & W_REG_EN;
    wreg_id0   = rstn ? rd_mem[head]    : '0;
    wreg_data0 = rstn ? data_mem[head]  : XLEN'(ZERO);
    wreg_id1   = rstn ? rd_mem[head1]   : '0;
    wreg_data1 = rstn ? data_mem[head1] : XLEN'(ZERO);
    q0_hit     = rstn && fwd0_hit;
    q1_hit     = rstn && fwd1_hit;
    q0_data    = rstn ? fwd0_data : XLEN'(ZERO);
    q1_data    = rstn ? fwd1_data : XLEN'(ZERO);
    count      = rstn ? cnt : '0;
    empty      = !rstn || (cnt == '0);
  end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed bench for rf_writeback_queue: expected writes go into a scoreboard
// queue and a negedge monitor pops them as the write ports fire.
module tb_rf_writeback_queue;

  localparam int XLEN      = 64;
  localparam int REG_IDX_W = 5;
  localparam int DEPTH     = 4;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 flush;
  logic                 wb_hold;
  logic                 in0_valid;
  logic [REG_IDX_W-1:0] in0_rd;
  logic [XLEN-1:0]      in0_data;
  logic                 in1_valid;
  logic [REG_IDX_W-1:0] in1_rd;
  logic [XLEN-1:0]      in1_data;
  logic                 in_ready;
  logic                 wen0;
  logic [REG_IDX_W-1:0] wreg_id0;
  logic [XLEN-1:0]      wreg_data0;
  logic                 wen1;
  logic [REG_IDX_W-1:0] wreg_id1;
  logic [XLEN-1:0]      wreg_data1;
  logic [REG_IDX_W-1:0] q0_id;
  logic [REG_IDX_W-1:0] q1_id;
  logic                 q0_hit;
  logic                 q1_hit;
  logic [XLEN-1:0]      q0_data;
  logic [XLEN-1:0]      q1_data;
  logic [2:0]           count;
  logic                 empty;

  typedef struct packed {
    logic [REG_IDX_W-1:0] id;
    logic [XLEN-1:0]      data;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  rf_writeback_queue #(
    .XLEN      (XLEN),
    .REG_IDX_W (REG_IDX_W),
    .DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (flush),
    .wb_hold    (wb_hold),
    .in0_valid  (in0_valid),
    .in0_rd     (in0_rd),
    .in0_data   (in0_data),
    .in1_valid  (in1_valid),
    .in1_rd     (in1_rd),
    .in1_data   (in1_data),
    .in_ready   (in_ready),
    .wen0       (wen0),
    .wreg_id0   (wreg_id0),
    .wreg_data0 (wreg_data0),
    .wen1       (wen1),
    .wreg_id1   (wreg_id1),
    .wreg_data1 (wreg_data1),
    .q0_id      (q0_id),
    .q1_id      (q1_id),
    .q0_hit     (q0_hit),
    .q1_hit     (q1_hit),
    .q0_data    (q0_data),
    .q1_data    (q1_data),
    .count      (count),
    .empty      (empty)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic mon_pop(input string port, input logic [REG_IDX_W-1:0] id,
                         input logic [XLEN-1:0] data);
    wr_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected: got write x%0d=0x%0h, expected no write", port, id, data);
    end else begin
      e = sb.pop_front();
      check({port, "_id"}, 64'(id), 64'(e.id));
      check({port, "_data"}, data, e.data);
    end
  endtask

  // Port 0 carries the older entry, so it is popped first.
  always @(negedge clk) begin
    if (rstn) begin
      if (wen0) mon_pop("wr0", wreg_id0, wreg_data0);
      if (wen1) mon_pop("wr1", wreg_id1, wreg_data1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic v0, input logic [REG_IDX_W-1:0] r0, input logic [XLEN-1:0] d0,
                       input logic v1, input logic [REG_IDX_W-1:0] r1, input logic [XLEN-1:0] d1);
    in0_valid = v0; in0_rd = r0; in0_data = d0;
    in1_valid = v1; in1_rd = r1; in1_data = d1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic expect_wr(input logic [REG_IDX_W-1:0] id, input logic [XLEN-1:0] data);
    sb.push_back('{id: id, data: data});
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; wb_hold = 1'b0;
    q0_id = '0; q1_id = '0;
    idle();

    // Reset state
    step(); step();
    settle();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_wen0", 64'(wen0), 64'd0);
    rstn = 1'b1;
    settle();
    check("post_rst_ready", 64'(in_ready), 64'd1);
    check("post_rst_empty", 64'(empty), 64'd1);

    // Pair in order
    step();
    drive(1'b1, 5'd5, 64'h11, 1'b1, 5'd6, 64'h22);
    expect_wr(5'd5, 64'h11); expect_wr(5'd6, 64'h22);
    settle();
    check("pair_ready", 64'(in_ready), 64'd1);
    check("pair_no_bypass", 64'(wen0), 64'd0);
    step(); idle(); settle();
    check("pair_wen0", 64'(wen0), 64'd1);
    check("pair_wen1", 64'(wen1), 64'd1);
    check("pair_count", 64'(count), 64'd2);
    step(); settle();
    check("pair_drained", 64'(count), 64'd0);
    check("pair_empty", 64'(empty), 64'd1);

    // x0 filtering
    drive(1'b1, 5'd0, 64'hAA, 1'b1, 5'd7, 64'hBB);
    expect_wr(5'd7, 64'hBB);
    step(); idle(); settle();
    check("x0_count", 64'(count), 64'd1);
    check("x0_wen0", 64'(wen0), 64'd1);
    check("x0_wen1", 64'(wen1), 64'd0);
    step(); settle();
    check("x0_drained", 64'(count), 64'd0);

    // Hold until full, then drain two per cycle
    wb_hold = 1'b1;
    drive(1'b1, 5'd1, 64'h101, 1'b1, 5'd2, 64'h102);
    expect_wr(5'd1, 64'h101); expect_wr(5'd2, 64'h102);
    step();
    drive(1'b1, 5'd3, 64'h103, 1'b1, 5'd4, 64'h104);
    expect_wr(5'd3, 64'h103); expect_wr(5'd4, 64'h104);
    step();
    drive(1'b1, 5'd10, 64'h110, 1'b1, 5'd11, 64'h111);
    q0_id = 5'd3; q1_id = 5'd8;
    settle();
    check("full_count", 64'(count), 64'd4);
    check("full_ready", 64'(in_ready), 64'd0);
    check("full_hold_wen0", 64'(wen0), 64'd0);
    check("fwd_hit3", 64'(q0_hit), 64'd1);
    check("fwd_data3", q0_data, 64'h103);
    check("fwd_miss8", 64'(q1_hit), 64'd0);
    q1_id = 5'd0;
    settle();
    check("fwd_x0_hit", 64'(q1_hit), 64'd0);
    check("fwd_x0_data", q1_data, 64'd0);
    step(); settle();
    check("full_not_accepted", 64'(count), 64'd4);
    idle(); wb_hold = 1'b0;
    settle();
    check("release_wen0", 64'(wen0), 64'd1);
    check("release_wen1", 64'(wen1), 64'd1);
    step(); settle();
    check("release_count2", 64'(count), 64'd2);
    step(); settle();
    check("release_count0", 64'(count), 64'd0);

    // Same destination on both lanes
    wb_hold = 1'b1;
    drive(1'b1, 5'd9, 64'd1, 1'b1, 5'd9, 64'd2);
    expect_wr(5'd9, 64'd1); expect_wr(5'd9, 64'd2);
    step(); idle(); q0_id = 5'd9; settle();
    check("same_count", 64'(count), 64'd2);
    check("same_fwd_hit", 64'(q0_hit), 64'd1);
    check("same_fwd_young", q0_data, 64'd2);
    wb_hold = 1'b0;
    settle();
    check("same_wen0", 64'(wen0), 64'd1);
    check("same_wen1", 64'(wen1), 64'd1);
    check("drain_still_hit", 64'(q0_hit), 64'd1);
    step(); settle();
    check("same_drained", 64'(count), 64'd0);

    // Flush at count 3 with valid inputs
    wb_hold = 1'b1;
    drive(1'b1, 5'd12, 64'hC1, 1'b1, 5'd13, 64'hC2);
    expect_wr(5'd12, 64'hC1); expect_wr(5'd13, 64'hC2);
    step();
    drive(1'b1, 5'd14, 64'hC3, 1'b0, '0, '0);
    expect_wr(5'd14, 64'hC3);
    step(); idle(); settle();
    check("cnt3_count", 64'(count), 64'd3);
    check("cnt3_ready", 64'(in_ready), 64'd0);
    step();
    wb_hold = 1'b0; flush = 1'b1;
    drive(1'b1, 5'd15, 64'hD1, 1'b1, 5'd16, 64'hD2);
    sb.delete();
    settle();
    check("flush_wen0", 64'(wen0), 64'd0);
    check("flush_wen1", 64'(wen1), 64'd0);
    check("flush_ready", 64'(in_ready), 64'd0);
    step(); flush = 1'b0; idle(); settle();
    check("flush_count", 64'(count), 64'd0);
    check("flush_empty", 64'(empty), 64'd1);
    check("flush_after_wen0", 64'(wen0), 64'd0);

    // Reset mid-stream at count 3
    wb_hold = 1'b1;
    drive(1'b1, 5'd17, 64'hE1, 1'b1, 5'd18, 64'hE2);
    expect_wr(5'd17, 64'hE1); expect_wr(5'd18, 64'hE2);
    step();
    drive(1'b1, 5'd19, 64'hE3, 1'b0, '0, '0);
    expect_wr(5'd19, 64'hE3);
    step(); idle(); settle();
    check("mid_count3", 64'(count), 64'd3);
    rstn = 1'b0;
    q0_id = 5'd17;
    sb.delete();
    settle();
    check("mid_rst_empty", 64'(empty), 64'd1);
    check("mid_rst_hit", 64'(q0_hit), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd0);
    step(); rstn = 1'b1; wb_hold = 1'b0; settle();
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_wen0", 64'(wen0), 64'd0);
    check("mid_rst_wen1", 64'(wen1), 64'd0);
    check("mid_rst_empty2", 64'(empty), 64'd1);

    // Simultaneous push and drain
    drive(1'b1, 5'd20, 64'hF0, 1'b1, 5'd21, 64'hF1);
    expect_wr(5'd20, 64'hF0); expect_wr(5'd21, 64'hF1);
    step();
    drive(1'b1, 5'd22, 64'hF2, 1'b0, '0, '0);
    expect_wr(5'd22, 64'hF2);
    q1_id = 5'd21;
    settle();
    check("sim_count2", 64'(count), 64'd2);
    check("sim_ready", 64'(in_ready), 64'd1);
    check("sim_fwd_hit", 64'(q1_hit), 64'd1);
    check("sim_fwd_data", q1_data, 64'hF1);
    step(); idle(); settle();
    check("sim_count1", 64'(count), 64'd1);
    check("sim_wen0", 64'(wen0), 64'd1);
    check("sim_wen1", 64'(wen1), 64'd0);
    step(); settle();
    check("sim_count0", 64'(count), 64'd0);

    step(); step(); step();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_writeback_queue.md
Name: rf_writeback_queue

Overview:
- Write-side producer for the dual-write-port integer register file.
- Buffers retired results from the dual-issue commit pair in program order and drains up to two per cycle onto register-file write ports 0 and 1 (port 0 older, port 1 younger).
- Provides two youngest-match forwarding query ports, so decode/issue can read values that are buffered but not yet written.

Parameters:
- XLEN, 64, data width.
- REG_IDX_W, 5, register index width.
- DEPTH, 4, queue entries; power of two, minimum 2.

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- flush  in  1  pipeline flush; discards all buffered entries
- wb_hold  in  1  blocks draining this cycle (CSR/debug use of write ports)
- in0_valid  in  1  older commit slot valid
- in0_rd  in  REG_IDX_W  older destination index
- in0_data  in  XLEN  older result
- in1_valid  in  1  younger commit slot valid
- in1_rd  in  REG_IDX_W  younger destination index
- in1_data  in  XLEN  younger result
- in_ready  out  1  queue accepts a commit pair this cycle
- wen0  out  1  write enable, port 0 (older)
- wreg_id0  out  REG_IDX_W  port 0 index
- wreg_data0  out  XLEN  port 0 data
- wen1  out  1  write enable, port 1 (younger)
- wreg_id1  out  REG_IDX_W  port 1 index
- wreg_data1  out  XLEN  port 1 data
- q0_id, q1_id  in  REG_IDX_W  forwarding query indices
- q0_hit, q1_hit  out  1  a buffered entry matches
- q0_data, q1_data  out  XLEN  youngest matching data
- count  out  clog2(DEPTH)+1  occupied entries
- empty  out  1  count==0

Behaviour:
- Reset: reset rstn, synchronous, active-low; clock clk. At the reset edge, head, tail and count clear to 0. While rstn is low, all outputs are forced to 0 (in_ready=0, wen0=wen1=0, ids/data 0, hits 0, empty=1).
- Storage: circular buffer of {rd, data}. Head and tail pointers wrap modulo DEPTH.
- Ready: in_ready = rstn && !flush && (DEPTH-count >= 2). It uses the pre-pop count, which is conservative and has no combinational path from wb_hold.
- Push (when in_ready): each valid slot with rd!=0 is written. rd==0 results are dropped and never stored.
  - Both stored: in0 goes to tail, in1 to tail+1.
  - Only one stored: it goes to tail.
  - Tail advances by the number stored (0..2).
  - Valid inputs while in_ready=0 are not accepted; the producer holds them.
- Drain (combinational from stored head entries):
  - wen0 = !wb_hold && !flush && count>=1, with head entry on port 0.
  - wen1 = !wb_hold && !flush && count>=2, with head+1 on port 1.
  - The entries are popped at the clock edge; head advances by wen0+wen1.
  - When wen0/wen1 are 0, the id/data outputs still show head contents; the register file ignores them.
- Same destination on both ports: both enables are asserted. The register file resolves this with port 1 (younger) winning. This is the required contract; no merging is done here.
- Simultaneous push and pop: allowed. count_next = count + pushed - popped.
- Latency: an entry pushed at edge N appears on the write ports during cycle N+1 at the earliest, and the register file updates at edge N+1. There is no bypass from inputs to outputs.
- Flush: has priority over push and drain. In the flush cycle wen0=wen1=0 and in_ready=0. At the next edge head, tail and count all clear. Flush during wb_hold behaves the same.
- Forwarding: each query scans the occupied entries (head .. head+count-1) and returns the youngest match.
  - q_id==0 gives hit=0, data=0.
  - Entries draining this cycle still count as hits.
  - Same-cycle inputs are not searched.
  - Queries are fully combinational.
- Ordering invariant: the register-file write order equals program order, lane0 before lane1 within each pair.

Decomposition:
- Shared params package gets the constants XLEN_BUS, REG_INDEX_BUS, W_REG_EN, RESET_EN and ZERO.
- One sub-module, rf_wbq_fwd_lookup: the youngest-match search. It is instantiated twice, once per query port, and takes the entry array, head and count.

Test Plan:
- Reset mid-stream: hold rstn=0 for one cycle while count=3 → next cycle count=0, wen0=wen1=0, empty=1.
- Pair in order: push {x5=0x11, x6=0x22} with no hold → next cycle wen0/x5/0x11 and wen1/x6/0x22, then count=0.
- x0 filtering: push {x0=0xAA, x7=0xBB} → count=1 and only wen0 asserts, with x7/0xBB.
- Hold and full: keep wb_hold=1 and push pairs until count=4 → in_ready=0. Release hold → drains two per cycle in push order.
- Same-destination pair and forwarding: push {x9=1, x9=2} with hold → q0_id=9 gives hit=1, data=2. Release → wen0 and wen1 both carry x9, with data 1 then 2.
- Flush: count=3 with in0/in1 valid and flush=1 → no write enables, no push; next cycle count=0.
